// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared RV32I load/store width codes, LSU FSM states and width helpers
package riscv_mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} lsu_state_t;
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    return sz == 2'b00 ? 4'b0001 : sz == 2'b01 ? 4'b0011 : 4'b1111;
  endfunction
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    return (f3 == F3_B || f3 == F3_H || f3 == F3_W) || (!store && (f3 == F3_BU || f3 == F3_HU));
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane mask, store data placement and load extraction/extension
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [63:0] rword,
  output logic [7:0]  mask,
  output logic [63:0] wdata_sh,
  output logic [31:0] rdata
);
  logic [31:0] rsh;
  logic        sx;
  // place store bytes at the offset, right-justify and extend load bytes
  always_comb begin
    mask     = {4'b0000, size_mask(funct3[1:0])} << off;
    wdata_sh = {32'b0, wdata} << {off, 3'b000};
    rsh      = 32'(rword >> {off, 3'b000});
    sx       = ~funct3[2];
    rdata    = funct3[1:0] == 2'b00 ? {{24{sx & rsh[7]}}, rsh[7:0]} :
               funct3[1:0] == 2'b01 ? {{16{sx & rsh[15]}}, rsh[15:0]} : rsh;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit splitting sub-word and misaligned accesses into word accesses
module lsu_ctrl
  import riscv_mem_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  lsu_state_t  state_q;
  logic        store_q, resp_valid_q, resp_err_q, mem_req_q, mem_we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, w0_q, resp_rdata_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic [29:0] mem_addr_q;
  logic        idle, split, err;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, ld;
  logic [63:0] rword, wd64;
  logic [7:0]  mask;
  // in IDLE the aligner sees the live request so access 0 can be registered at accept
  always_comb begin
    idle  = state_q == IDLE;
    f3    = idle ? req_funct3 : f3_q;
    addr  = idle ? req_addr : addr_q;
    wdata = idle ? req_wdata : wdata_q;
    rword = state_q == WAIT1 ? {mem_rdata, w0_q} : {32'b0, mem_rdata};
  end
  lsu_align u_align (
    .funct3(f3), .off(addr[1:0]), .wdata(wdata), .rword(rword),
    .mask(mask), .wdata_sh(wd64), .rdata(ld)
  );
  // a request crossing a word needs a second access; strict mode rejects any misalignment
  always_comb begin
    split = mask[7:4] != 4'b0000;
    err   = !f3_legal(req_store, req_funct3) ||
            (!ALLOW_MISALIGNED && (split || (f3[1:0] == 2'b01 && addr[0]) ||
                                   (f3[1:0] == 2'b10 && addr[1:0] != 2'b00)));
  end
  // request/response FSM with registered memory and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      {store_q, f3_q, addr_q, wdata_q, w0_q} <= '0;
      {resp_valid_q, resp_err_q, resp_rdata_q} <= '0;
      {mem_req_q, mem_we_q, mem_be_q, mem_addr_q, mem_wdata_q} <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        IDLE: if (req_valid) begin
          store_q <= req_store;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          if (err) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            state_q     <= ISSUE0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_store;
            mem_be_q    <= mask[3:0];
            mem_addr_q  <= req_addr[31:2];
            mem_wdata_q <= wd64[31:0];
          end
        end
        ISSUE0: if (mem_gnt) begin
          if (store_q && split) begin
            state_q     <= ISSUE1;
            mem_be_q    <= mask[7:4];
            mem_addr_q  <= addr_q[31:2] + 30'd1;
            mem_wdata_q <= wd64[63:32];
          end else begin
            state_q      <= store_q ? RESP : WAIT0;
            mem_req_q    <= 1'b0;
            resp_valid_q <= store_q;
          end
        end
        WAIT0: if (mem_rvalid) begin
          w0_q <= mem_rdata;
          if (split) begin
            state_q     <= ISSUE1;
            mem_req_q   <= 1'b1;
            mem_be_q    <= mask[7:4];
            mem_addr_q  <= addr_q[31:2] + 30'd1;
            mem_wdata_q <= wd64[63:32];
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ld;
          end
        end
        ISSUE1: if (mem_gnt) begin
          state_q      <= store_q ? RESP : WAIT1;
          mem_req_q    <= 1'b0;
          resp_valid_q <= store_q;
        end
        WAIT1: if (mem_rvalid) begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= ld;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready  = state_q == IDLE;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench with a word memory model for both lsu_ctrl variants
module tb_lsu_ctrl;
  import riscv_mem_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        req_valid = 0, req_valid_s = 0, req_store = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_wdata;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic        mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;
  logic        req_ready_s, resp_valid_s, resp_err_s, mem_req_s, mem_we_s;
  logic [31:0] resp_rdata_s, mem_wdata_s;
  logic [3:0]  mem_be_s;
  logic [29:0] mem_addr_s;
  logic        mem_gnt_s = 0, mem_rvalid_s = 0, rpend_s = 0;
  logic [31:0] mem_rdata_s = 32'h12345678;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  lsu_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut_s (
    .clk(clk), .rst(rst), .req_valid(req_valid_s), .req_ready(req_ready_s), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_s),
    .resp_rdata(resp_rdata_s), .resp_err(resp_err_s), .mem_req(mem_req_s), .mem_we(mem_we_s),
    .mem_be(mem_be_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .mem_gnt(mem_gnt_s),
    .mem_rvalid(mem_rvalid_s), .mem_rdata(mem_rdata_s)
  );

  typedef struct {logic we; logic [3:0] be; logic [29:0] addr; logic [31:0] wdata;} acc_t;
  typedef struct {logic err; logic [31:0] rdata; int lat;} rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];
  logic [31:0] mem [logic [29:0]];
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, n_resp = 0, gnt_delay = 0, req_age = 0;
  logic hold_rv = 0, inject = 0, rd_pend = 0;
  logic [31:0] rd_word = 0, bm, w;
  logic [67:0] saved;
  acc_t a;
  rsp_t r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void exp_acc(input logic we, input logic [3:0] be, input logic [29:0] ad, input logic [31:0] wd);
    acc_q.push_back('{we, be, ad, wd});
  endfunction
  function automatic void exp_rsp(input logic e, input logic [31:0] rd, input int lat);
    rsp_q.push_back('{e, rd, lat});
  endfunction

  always @(posedge clk) cyc++;

  // memory model, access scoreboard and response scoreboard
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (rd_pend && !hold_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd_word;
      rd_pend    = 1'b0;
    end
    if (inject) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0BAD0;
    end
    mem_rvalid_s = rpend_s;
    rpend_s      = mem_req_s & ~mem_we_s;
    mem_gnt_s    = mem_req_s;
    mem_gnt      = mem_req && req_age >= gnt_delay;
    if (mem_req && req_age > 0) chk("req_stable", {mem_we, mem_be, mem_addr, mem_wdata}, saved);
    if (mem_req && !mem_gnt) begin
      req_age++;
      saved = {mem_we, mem_be, mem_addr, mem_wdata};
    end else req_age = 0;
    if (mem_req && mem_gnt) begin
      if (acc_q.size() == 0) chk("acc_unexpected", mem_req, 0);
      else begin
        a = acc_q.pop_front();
        chk("acc_we", mem_we, a.we);
        chk("acc_be", mem_be, a.be);
        chk("acc_addr", mem_addr, a.addr);
        bm = {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}};
        w  = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        if (mem_we) begin
          chk("acc_wdata", mem_wdata & bm, a.wdata & bm);
          mem[mem_addr] = (w & ~bm) | (mem_wdata & bm);
        end else begin
          rd_word = w;
          rd_pend = 1'b1;
        end
      end
    end
    if (resp_valid) begin
      n_resp++;
      if (rsp_q.size() == 0) chk("resp_unexpected", resp_valid, 0);
      else begin
        r = rsp_q.pop_front();
        chk("resp_err", resp_err, r.err);
        chk("resp_rdata", resp_rdata, r.rdata);
        if (r.lat >= 0) chk("resp_latency", cyc - acc_cyc, r.lat);
      end
    end
    if (req_valid && req_ready) acc_cyc = cyc;
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd);
    @(posedge clk); #1;
    req_valid = 1; req_store = st; req_funct3 = f3; req_addr = ad; req_wdata = wd;
    @(posedge clk); #1 req_valid = 0;
  endtask
  task automatic wait_done(input string tag);
    for (int i = 0; i < 40 && (rsp_q.size() != 0 || acc_q.size() != 0); i++) @(posedge clk);
    chk({tag, "_resp_pending"}, rsp_q.size(), 0);
    chk({tag, "_acc_pending"}, acc_q.size(), 0);
  endtask
  task automatic strict(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] ad,
                        input logic e, input logic [31:0] rd, input int lat);
    int l;
    logic saw;
    l = 0; saw = 0;
    @(posedge clk); #1;
    req_valid_s = 1; req_store = st; req_funct3 = f3; req_addr = ad; req_wdata = 0;
    @(posedge clk); #1 req_valid_s = 0;
    for (int i = 1; i <= 8 && l == 0; i++) begin
      @(negedge clk);
      saw = saw | mem_req_s;
      if (resp_valid_s) begin
        l = i;
        chk({tag, "_err"}, resp_err_s, e);
        chk({tag, "_rdata"}, resp_rdata_s, rd);
      end
    end
    chk({tag, "_latency"}, l, lat);
    chk({tag, "_mem_req"}, saw, !e);
  endtask

  initial begin
    int n0;
    mem[30'd1] = 32'h44332211;
    mem[30'd2] = 32'h88776655;
    mem[30'd4] = 32'h80FF0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp", {resp_valid, resp_err, resp_rdata}, 0);
    chk("rst_mem", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 0);
    @(posedge clk); #1 rst = 0;

    exp_acc(0, 4'b1000, 30'd4, 0); exp_rsp(0, 32'hFFFFFF80, 3);
    issue(0, F3_B, 32'h13, 0); wait_done("lb");
    exp_acc(0, 4'b1000, 30'd4, 0); exp_rsp(0, 32'h00000080, 3);
    issue(0, F3_BU, 32'h13, 0); wait_done("lbu");
    exp_acc(1, 4'b1111, 30'd4, 32'hDEADBEEF); exp_rsp(0, 0, 2);
    issue(1, F3_W, 32'h10, 32'hDEADBEEF); wait_done("sw");
    exp_acc(0, 4'b1100, 30'd4, 0); exp_rsp(0, 32'hFFFFDEAD, 3);
    issue(0, F3_H, 32'h12, 0); wait_done("lh");
    exp_acc(0, 4'b0011, 30'd4, 0); exp_rsp(0, 32'h0000BEEF, 3);
    issue(0, F3_HU, 32'h10, 0); wait_done("lhu");

    exp_acc(0, 4'b1100, 30'd1, 0); exp_acc(0, 4'b0011, 30'd2, 0); exp_rsp(0, 32'h66554433, 5);
    issue(0, F3_W, 32'h06, 0); wait_done("lw_split");
    exp_acc(1, 4'b1000, 30'd1, 32'hCD000000); exp_acc(1, 4'b0001, 30'd2, 32'h000000AB); exp_rsp(0, 0, 3);
    issue(1, F3_H, 32'h07, 32'h0000ABCD); wait_done("sh_split");
    exp_acc(0, 4'b1000, 30'd1, 0); exp_acc(0, 4'b0001, 30'd2, 0); exp_rsp(0, 32'hFFFFABCD, 5);
    issue(0, F3_H, 32'h07, 0); wait_done("lh_split");

    exp_rsp(1, 0, 1);
    issue(1, F3_BU, 32'h20, 32'h1); wait_done("st_f3_100");
    exp_rsp(1, 0, 1);
    issue(0, 3'b011, 32'h20, 0); wait_done("ld_f3_011");

    gnt_delay = 2;
    exp_acc(1, 4'b0010, 30'd0, 32'h00005A00); exp_rsp(0, 0, -1);
    issue(1, F3_B, 32'h01, 32'h0000005A); wait_done("sb_slow_gnt");
    gnt_delay = 0;
    exp_acc(1, 4'b1100, 30'h3FFFFFFF, 32'h33440000); exp_acc(1, 4'b0011, 30'd0, 32'h00001122); exp_rsp(0, 0, 3);
    issue(1, F3_W, 32'hFFFFFFFE, 32'h11223344); wait_done("sw_wrap");

    hold_rv = 1;
    n0 = n_resp;
    exp_acc(0, 4'b1111, 30'd4, 0);
    issue(0, F3_W, 32'h10, 0);
    @(posedge clk); #1;
    chk("rst_in_wait0_state", dut.state_q, WAIT0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; hold_rv = 0; rd_pend = 0;
    chk("rst_abort_state", dut.state_q, IDLE);
    chk("rst_abort_mem_req", mem_req, 0);
    chk("rst_abort_ready", req_ready, 1);
    inject = 1;
    @(posedge clk); #1 inject = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("stale_rvalid_state", dut.state_q, IDLE);
    chk("stale_rvalid_no_resp", n_resp - n0, 0);
    chk("stale_rvalid_acc", acc_q.size(), 0);

    strict("strict_lw_02", 0, F3_W, 32'h02, 1, 0, 1);
    strict("strict_lh_01", 0, F3_H, 32'h01, 1, 0, 1);
    strict("strict_lw_04", 0, F3_W, 32'h04, 0, 32'h12345678, 3);
    strict("strict_lb_03", 0, F3_B, 32'h03, 0, 32'h00000012, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
